alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single ALU instance (add/sub/Karatsuba multiply/restoring divide, start/done handshake) between two requesters, e.g. the instruction sequencer and the address-generation unit.
- Accepts one operation at a time from each requester under round-robin arbitration.
- Drives the ALU start pulse and waits for ALU done.
- Returns result_low/result_high to the requester whose operation was issued.
- Sits between the requesters and the ALU. It owns alu_start exclusively.

Parameters:
- WIDTH, 16, operand and result half-width; must match the ALU.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the watchdog fires (only with ALU_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester operation request (bit i = requester i)
- req_ready  out  2  per-requester accept; handshake completes when req_valid[i] & req_ready[i]
- req0_opcode, req1_opcode  in  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div)
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  signed operands
- resp_valid  out  2  one-cycle response strobe, per requester
- resp_low, resp_high  out  WIDTH  result halves, valid while any resp_valid bit is high
- resp_err  out  1  timeout flag, qualified by resp_valid
- alu_start  out  1  ALU start
- alu_opcode  out  3  ALU opcode
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_done  in  1  ALU done
- alu_result_low, alu_result_high  in  WIDTH  ALU results

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - State=IDLE; last_grant=1, so requester 0 wins first.
  - All outputs 0; the latched opcode and operands are 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational from req_valid.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_grant wins.
  - req_ready is asserted for the winner only.
  - On the handshake edge: latch opcode/a/b into alu_* registers, record the owner, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: alu_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - alu_done is sampled only in this state; it is ignored in all other states.
  - On alu_done=1: capture alu_result_low/high into resp_low/high, go to RESP.
- RESP:
  - resp_valid[owner]=1 for one cycle; last_grant<=owner; go to IDLE.
  - resp_low/high hold their values until the next capture.
- Spacing guarantee: the RESP and IDLE cycles give at least 2 cycles between the done capture and the next alu_start. This covers the ALU's post-mul/div FINISH cycle and its stale done, so no start is ever lost.
- Latency:
  - Add/sub: resp_valid is high in the 3rd cycle after the handshake cycle.
  - Mul/div: 2 + ALU latency.
  - Minimum occupancy is 4 cycles per operation.
- Arithmetic: the block is pass-through only.
  - Divide by zero returns 0/0 from the ALU, forwarded with resp_err=0.
  - Unsupported opcodes are forwarded; the ALU returns 0/0.
- Simultaneous events:
  - A requester that is granted and re-requests immediately loses to a waiting peer.
  - A new req_valid during ISSUE/WAIT/RESP waits; it is never dropped.
- Reset mid-operation: the operation is abandoned and no resp_valid is produced. The ALU shares reset.

Optional Feature:
- Macro ALU_ARB_TIMEOUT_EN.
- With the macro:
  - A counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without alu_done, go to RESP with resp_err=1 and resp_low/high=0.
  - The ALU is not recovered; the system must pulse reset.
- Without the macro: no counter; WAIT is unbounded; resp_err is tied to 0.

Decomposition:
- Package alu_arb_pkg:
  - state encoding (IDLE/ISSUE/WAIT/RESP)
  - opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - default WIDTH
  - default TIMEOUT_CYCLES
- Sub-module rr_arbiter_2:
  - combinational two-way round-robin grant from req_valid and last_grant
  - plus the registered last_grant update on grant_commit.

Test Plan:
- Reset, then req0 add a=5 b=7 -> req_ready[0] same cycle; alu_start 1 cycle later; resp_valid[0] with resp_low=12, resp_high=0, resp_err=0.
- req1 sub a=3 b=5 -> resp_valid[1], resp_low=16'hFFFE, resp_high=16'hFFFF.
- req0 mul a=300 b=200 -> resp_low=16'hEA60, resp_high=0.
  - Then req1 div a=100 b=7 issued immediately -> alu_start is at least 2 cycles after done.
  - Response: quotient 14 (resp_low), remainder 2 (resp_high).
- Both req_valid held high from reset with add ops -> grants alternate 0,1,0,1; each response goes only to its owner.
- Div a=9 b=0 -> resp_low=0, resp_high=0, resp_err=0.
- Reset asserted mid-mul in WAIT -> no resp_valid; next req0 add 1+1 returns 2.
- With ALU_ARB_TIMEOUT_EN: ALU model holds done=0 -> resp_valid after 64 WAIT cycles with resp_err=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants for the ALU arbiter slice.
//   - default operand half-width and watchdog limit
//   - FSM state encoding (IDLE/ISSUE/WAIT/RESP)
//   - ALU opcode constants
package alu_arb_pkg;

   localparam int unsigned ALU_ARB_WIDTH          = 16;
   localparam int unsigned ALU_ARB_TIMEOUT_CYCLES = 64;
   localparam int unsigned OPC_W                  = 3;
   localparam int unsigned STATE_W                = 2;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
   localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

   localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
   localparam logic [OPC_W-1:0] OP_MUL = 3'b010;
   localparam logic [OPC_W-1:0] OP_DIV = 3'b011;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bus of the ALU arbiter.
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   reqN_opcode/a/b       per-requester operation payload
//   resp_valid            one-cycle response strobe per requester
//   resp_low/high/err     shared response payload, qualified by resp_valid
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
   parameter int unsigned WIDTH = alu_arb_pkg::ALU_ARB_WIDTH
);
   logic [1:0]                         req_valid;
   logic [1:0]                         req_ready;
   logic [alu_arb_pkg::OPC_W-1:0]      req0_opcode;
   logic [alu_arb_pkg::OPC_W-1:0]      req1_opcode;
   logic [WIDTH-1:0]                   req0_a;
   logic [WIDTH-1:0]                   req0_b;
   logic [WIDTH-1:0]                   req1_a;
   logic [WIDTH-1:0]                   req1_b;
   logic [1:0]                         resp_valid;
   logic [WIDTH-1:0]                   resp_low;
   logic [WIDTH-1:0]                   resp_high;
   logic                               resp_err;

   modport master (
      output req_valid, req0_opcode, req1_opcode, req0_a, req0_b, req1_a, req1_b,
      input  req_ready, resp_valid, resp_low, resp_high, resp_err
   );

   modport slave (
      input  req_valid, req0_opcode, req1_opcode, req0_a, req0_b, req1_a, req1_b,
      output req_ready, resp_valid, resp_low, resp_high, resp_err
   );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant.
//   clk, reset    clock, async active-high reset
//   req_valid     request bits (bit i = requester i)
//   grant_commit  pulse: record commit_id as the last served requester
//   commit_id     requester that was just served
//   grant_c       combinational one-hot grant (0 when nothing is requested)
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_valid,
   input  logic       grant_commit,
   input  logic       commit_id,
   output logic [1:0] grant_c
);

   logic last_grant;

   // Reset to 1 so requester 0 wins the first contested round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             last_grant <= 1'b1;
      else if (grant_commit) last_grant <= commit_id;
   end

   // Under contention the requester that was not served last wins.
   always_comb begin
      grant_c = 2'b00;
      case (req_valid)
         2'b01:   grant_c = 2'b01;
         2'b10:   grant_c = 2'b10;
         2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
         default: grant_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one start/done ALU between two requesters.
//   clk, reset          clock, async active-high reset (ALU shares it)
//   bus (slave)         requester handshake, payload and responses
//   alu_start           one-cycle start pulse, owned exclusively here
//   alu_opcode/a/b      latched operation of the current owner
//   alu_done            ALU completion, honoured only while waiting
//   alu_result_low/high ALU result halves
// Optional macro ALU_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES
// that answers with resp_err=1 and a zero result; without it resp_err is 0.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned WIDTH          = ALU_ARB_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = ALU_ARB_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   alu_arbiter_if.slave      bus,
   output logic              alu_start,
   output logic [OPC_W-1:0]  alu_opcode,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic              alu_done,
   input  logic [WIDTH-1:0]  alu_result_low,
   input  logic [WIDTH-1:0]  alu_result_high
);

   logic [STATE_W-1:0] state, state_n;
   logic               owner, owner_n;
   logic               start_n;
   logic [OPC_W-1:0]   opcode_n;
   logic [WIDTH-1:0]   a_n, b_n;
   logic [1:0]         resp_valid_q, resp_valid_n;
   logic [WIDTH-1:0]   resp_low_q, resp_low_n;
   logic [WIDTH-1:0]   resp_high_q, resp_high_n;
   logic [1:0]         grant_c;
   logic               commit_c;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] timer, timer_n;
   logic             resp_err_q, resp_err_n;
`endif

   rr_arbiter_2 u_rr (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (bus.req_valid),
      .grant_commit (commit_c),
      .commit_id    (owner),
      .grant_c      (grant_c)
   );

   // Ready only offered in IDLE, and only to the round-robin winner.
   assign bus.req_ready  = (state == ST_IDLE) ? grant_c : 2'b00;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_low   = resp_low_q;
   assign bus.resp_high  = resp_high_q;
`ifdef ALU_ARB_TIMEOUT_EN
   assign bus.resp_err   = resp_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign bus.resp_err   = 1'b0;
`endif

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         owner        <= 1'b0;
         alu_start    <= 1'b0;
         alu_opcode   <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         resp_valid_q <= '0;
         resp_low_q   <= '0;
         resp_high_q  <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         timer        <= '0;
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         owner        <= owner_n;
         alu_start    <= start_n;
         alu_opcode   <= opcode_n;
         alu_a        <= a_n;
         alu_b        <= b_n;
         resp_valid_q <= resp_valid_n;
         resp_low_q   <= resp_low_n;
         resp_high_q  <= resp_high_n;
`ifdef ALU_ARB_TIMEOUT_EN
         timer        <= timer_n;
         resp_err_q   <= resp_err_n;
`endif
      end
   end

   // Next state and next values of registered outputs.
   always_comb begin
      state_n      = state;
      owner_n      = owner;
      start_n      = 1'b0;
      opcode_n     = alu_opcode;
      a_n          = alu_a;
      b_n          = alu_b;
      resp_valid_n = 2'b00;
      resp_low_n   = resp_low_q;
      resp_high_n  = resp_high_q;
      commit_c     = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      timer_n      = timer;
      resp_err_n   = resp_err_q;
`endif
      case (state)
         ST_IDLE: begin
            // grant_c is non-zero only for a valid requester: handshake edge.
            if (|grant_c) begin
               owner_n  = grant_c[1];
               opcode_n = grant_c[1] ? bus.req1_opcode : bus.req0_opcode;
               a_n      = grant_c[1] ? bus.req1_a      : bus.req0_a;
               b_n      = grant_c[1] ? bus.req1_b      : bus.req0_b;
               start_n  = 1'b1;
               state_n  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_n = ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
            timer_n = '0;
`endif
         end
         ST_WAIT: begin
            if (alu_done) begin
               resp_low_n   = alu_result_low;
               resp_high_n  = alu_result_high;
               resp_valid_n = owner ? 2'b10 : 2'b01;
               state_n      = ST_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
               resp_err_n   = 1'b0;
`endif
            end
`ifdef ALU_ARB_TIMEOUT_EN
            else if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               resp_low_n   = '0;
               resp_high_n  = '0;
               resp_err_n   = 1'b1;
               resp_valid_n = owner ? 2'b10 : 2'b01;
               state_n      = ST_RESP;
            end else begin
               timer_n = timer + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            // RESP plus the following IDLE keep two cycles between done and next start.
            commit_c = 1'b1;
            state_n  = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small
// behavioural start/done ALU (add/sub/other in 1 cycle, mul/div in MD_LAT).
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int unsigned W      = 16;
   localparam int unsigned MD_LAT = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_start;
   logic [2:0]    alu_opcode;
   logic [W-1:0]  alu_a, alu_b;
   logic          alu_done;
   logic [W-1:0]  alu_result_low, alu_result_high;
   logic          hang;

   int n_checks = 0;
   int n_pass   = 0;

   alu_arbiter_if #(.WIDTH(W)) bus ();

   alu_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .alu_start       (alu_start),
      .alu_opcode      (alu_opcode),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_done        (alu_done),
      .alu_result_low  (alu_result_low),
      .alu_result_high (alu_result_high)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- behavioural ALU ----------------
   function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      int ia, ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      case (op)
         3'b000: alu_calc = 32'(ia + ib);
         3'b001: alu_calc = 32'(ia - ib);
         3'b010: alu_calc = 32'(ia * ib);
         3'b011: alu_calc = (ib == 0) ? 32'd0 : {16'(ia % ib), 16'(ia / ib)};
         default: alu_calc = 32'd0;
      endcase
   endfunction

   logic       busy;
   int         cnt;
   logic [31:0] res;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_done <= 1'b0; busy <= 1'b0; cnt <= 0;
         alu_result_low <= '0; alu_result_high <= '0;
      end else begin
         alu_done <= 1'b0;
         if (busy && !hang) begin
            if (cnt == 0) begin alu_done <= 1'b1; busy <= 1'b0; end
            else cnt <= cnt - 1;
         end
         if (alu_start) begin
            res = alu_calc(alu_opcode, alu_a, alu_b);
            alu_result_low  <= res[15:0];
            alu_result_high <= res[31:16];
            if (alu_opcode == OP_MUL || alu_opcode == OP_DIV) begin
               busy <= 1'b1; cnt <= MD_LAT - 2;
            end else if (!hang) begin
               alu_done <= 1'b1;
            end
         end
      end
   end

   // ---------------- start spacing monitor ----------------
   int cyc = 0, done_cyc = 0;
   bit have_done = 0;
   always @(negedge clk) begin
      if (reset) begin
         have_done = 0;
      end else begin
         cyc++;
         if (alu_start && have_done) chk("start_spacing", 32'(cyc - done_cyc >= 3), 32'd1);
         if (alu_done) begin have_done = 1; done_cyc = cyc; end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic do_op(input string tag, input int id, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input logic exp_err, input int exp_lat);
      int n;
      logic [1:0] me;
      me = 2'(1 << id);
      if (id == 0) begin bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; end
      else         begin bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; end
      bus.req_valid = me;
      #1;
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(me));
      step();
      bus.req_valid = 2'b00;
      chk({tag, "_start"}, 32'(alu_start), 32'd1);
      chk({tag, "_opcode"}, 32'(alu_opcode), 32'(op));
      chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
      chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
      step();
      n = 2;
      chk({tag, "_start_pulse"}, 32'(alu_start), 32'd0);
      while (bus.resp_valid == 2'b00 && n < 200) begin step(); n++; end
      chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(me));
      chk({tag, "_resp_low"}, 32'(bus.resp_low), 32'(exp_lo));
      chk({tag, "_resp_high"}, 32'(bus.resp_high), 32'(exp_hi));
      chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'(exp_err));
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      step();
      chk({tag, "_resp_drop"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_resp_hold"}, 32'(bus.resp_low), 32'(exp_lo));
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n, seen;
      logic [1:0] exp_g;
      reset = 1'b1;
      hang  = 1'b0;
      bus.req_valid = 2'b00;
      bus.req0_opcode = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_opcode = '0; bus.req1_a = '0; bus.req1_b = '0;
      step();

      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_alu_start", 32'(alu_start), 32'd0);
      chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_low", 32'(bus.resp_low), 32'd0);
      chk("rst_resp_high", 32'(bus.resp_high), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      apply_reset();

      do_op("add", 0, OP_ADD, 16'd5, 16'd7, 16'd12, 16'h0000, 1'b0, 3);
      do_op("sub", 1, OP_SUB, 16'd3, 16'd5, 16'hFFFE, 16'hFFFF, 1'b0, 3);
      do_op("mul", 0, OP_MUL, 16'd300, 16'd200, 16'hEA60, 16'h0000, 1'b0, 2 + MD_LAT);
      do_op("div", 1, OP_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 2 + MD_LAT);
      do_op("div0", 0, OP_DIV, 16'd9, 16'd0, 16'd0, 16'd0, 1'b0, 2 + MD_LAT);
      do_op("badop", 1, 3'b111, 16'd5, 16'd6, 16'd0, 16'd0, 1'b0, 3);

      // Both requesters held valid from reset: grants alternate 0,1,0,1.
      bus.req0_opcode = OP_ADD; bus.req0_a = 16'd10; bus.req0_b = 16'd1;
      bus.req1_opcode = OP_ADD; bus.req1_a = 16'd20; bus.req1_b = 16'd2;
      bus.req_valid = 2'b11;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         n = 0;
         while (bus.req_ready == 2'b00 && n < 20) begin step(); n++; end
         chk("rr_grant", 32'(bus.req_ready), 32'(exp_g));
         step();
         n = 0;
         while (bus.resp_valid == 2'b00 && n < 50) begin step(); n++; end
         chk("rr_owner", 32'(bus.resp_valid), 32'(exp_g));
         chk("rr_low", 32'(bus.resp_low), (k % 2 == 0) ? 32'd11 : 32'd22);
         step();
      end
      bus.req_valid = 2'b00;
      step();

      // Reset while waiting on a multiply: operation abandoned, no response.
      bus.req0_opcode = OP_MUL; bus.req0_a = 16'd7; bus.req0_b = 16'd8;
      bus.req_valid = 2'b01;
      #1;
      step();
      bus.req_valid = 2'b00;
      step();
      reset = 1'b1;
      #1;
      chk("midrst_start", 32'(alu_start), 32'd0);
      chk("midrst_opcode", 32'(alu_opcode), 32'd0);
      chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      step();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.resp_valid != 2'b00) seen++;
      end
      chk("midrst_no_resp", 32'(seen), 32'd0);
      do_op("post_rst_add", 0, OP_ADD, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 3);

`ifdef ALU_ARB_TIMEOUT_EN
      // ALU never answers: watchdog responds after 64 WAIT cycles.
      hang = 1'b1;
      do_op("timeout", 0, OP_MUL, 16'd3, 16'd4, 16'd0, 16'd0, 1'b1, 66);
      hang = 1'b0;
      apply_reset();
      do_op("post_to_add", 1, OP_ADD, 16'd2, 16'd3, 16'd5, 16'd0, 1'b0, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
